// File: rtl/issue_select_if.sv
// Issue-select bus: dispatch/request inputs from wakeup and the FU
// handshake, bundled so the select stage and its neighbours share one port.
interface issue_select_if #(
    parameter int RS_ENTRIES = 8,
    parameter int IDX_W      = $clog2(RS_ENTRIES)
);
    logic                  disp_valid;
    logic [IDX_W-1:0]      disp_entry;
    logic [RS_ENTRIES-1:0] reqs;
    logic                  flush;
    logic                  fu_ready;
    logic [RS_ENTRIES-1:0] grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic [RS_ENTRIES-1:0] issued_mask;

    // Driver side: wakeup/dispatch/FU sources feeding the select stage.
    modport master (
        output disp_valid, disp_entry, reqs, flush, fu_ready,
        input  grant, grant_idx, grant_valid, issued_mask
    );

    // Select stage side.
    modport slave (
        input  disp_valid, disp_entry, reqs, flush, fu_ready,
        output grant, grant_idx, grant_valid, issued_mask
    );
endinterface

// File: rtl/issue_select.sv
// issue_select: picks the oldest ready reservation-station entry using an
// age matrix and presents it as a registered one-hot grant with a
// valid/ready handshake. A local issued mask blocks double issue until the
// entry is dispatched again.
// Optional statistics counters are enabled with `define ISSUE_SELECT_STATS_EN.
module issue_select #(
    parameter int RS_ENTRIES = 8,
    parameter int IDX_W      = $clog2(RS_ENTRIES),
    parameter int STAT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    issue_select_if.slave       bus
`ifdef ISSUE_SELECT_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_issued,
    output logic [STAT_W-1:0]   stat_stall
`endif
);

    // age[i][j] = 1 : entry i was dispatched before entry j
    logic [RS_ENTRIES-1:0] r_age [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] w_age_nxt [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] r_ev;
    logic [RS_ENTRIES-1:0] r_issued;
    logic [RS_ENTRIES-1:0] w_issued_nxt;
    logic [RS_ENTRIES-1:0] r_grant;
    logic [IDX_W-1:0]      r_grant_idx;
    logic                  r_grant_valid;

    logic                  w_accept;
    logic [RS_ENTRIES-1:0] w_accept_oh;
    logic [RS_ENTRIES-1:0] w_cand;
    logic [RS_ENTRIES-1:0] w_pick;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_load;

    // The FU takes the presented grant this cycle; a flush overrides it.
    assign w_accept    = r_grant_valid && bus.fu_ready && !bus.flush;
    assign w_accept_oh = w_accept ? r_grant : '0;
    // The entry being accepted must not be picked again on the same edge.
    assign w_cand      = bus.reqs & r_ev & ~r_issued & ~w_accept_oh;
    // The grant register only moves when it is empty or being consumed.
    assign w_load      = !r_grant_valid || bus.fu_ready;

    // Oldest-first pick: a candidate wins if it is older than every other candidate.
    always_comb begin
        logic v_oldest;
        w_pick   = '0;
        v_oldest = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            v_oldest = w_cand[i];
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (j != i && w_cand[j] && !r_age[i][j]) begin
                    v_oldest = 1'b0;
                end
            end
            w_pick[i] = v_oldest;
        end
    end

    // One-hot to binary encode of the pick.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = w_pick_idx | IDX_W'(i);
            end
        end
    end

    // Next age matrix: a dispatched entry becomes younger than every valid entry.
    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_age_nxt[i] = r_age[i];
        end
        if (bus.disp_valid) begin
            for (int j = 0; j < RS_ENTRIES; j++) begin
                w_age_nxt[j][bus.disp_entry] = r_ev[j];
            end
            w_age_nxt[bus.disp_entry] = '0;
        end
    end

    // Next issued mask: accept marks the granted entry, dispatch clears it.
    always_comb begin
        w_issued_nxt = r_issued | w_accept_oh;
        if (bus.disp_valid) begin
            w_issued_nxt[bus.disp_entry] = 1'b0;
        end
    end

    // Age matrix register; kept across flush because ev gates stale rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_age[i] <= '0;
            end
        end else if (!bus.flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_age[i] <= w_age_nxt[i];
            end
        end
    end

    // Entry-valid and issued-mask registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ev     <= '0;
            r_issued <= '0;
        end else if (bus.flush) begin
            r_ev     <= '0;
            r_issued <= '0;
        end else begin
            r_issued <= w_issued_nxt;
            if (bus.disp_valid) begin
                r_ev[bus.disp_entry] <= 1'b1;
            end
        end
    end

    // Grant register: holds during a stall, otherwise loads the current pick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
        end else if (bus.flush) begin
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
        end else if (w_load) begin
            r_grant       <= w_pick;
            r_grant_idx   <= w_pick_idx;
            r_grant_valid <= |w_pick;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_idx   = r_grant_idx;
    assign bus.grant_valid = r_grant_valid;
    assign bus.issued_mask = r_issued;

`ifdef ISSUE_SELECT_STATS_EN
    logic [STAT_W-1:0] r_stat_issued;
    logic [STAT_W-1:0] r_stat_stall;
    logic              w_stall;

    assign w_stall = r_grant_valid && !bus.fu_ready;

    // Saturating accept/stall counters; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_accept && (r_stat_issued != '1)) begin
                r_stat_issued <= r_stat_issued + STAT_W'(1);
            end
            if (w_stall && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + STAT_W'(1);
            end
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select: a sequence-number reference model predicts the
// grant register, issued mask and counters each cycle; predictions are
// queued when stimulus is applied and compared after the clock edge.
module tb_issue_select;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int SW = 32;

    logic clk;
    logic rst;

    issue_select_if #(.RS_ENTRIES(N), .IDX_W(IW)) bus ();

`ifdef ISSUE_SELECT_STATS_EN
    logic [SW-1:0] stat_issued;
    logic [SW-1:0] stat_stall;
`endif

    issue_select #(.RS_ENTRIES(N), .IDX_W(IW), .STAT_W(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef ISSUE_SELECT_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          gv;
        logic [IW-1:0] gidx;
        logic [N-1:0]  grant;
        logic [N-1:0]  iss;
        logic [SW-1:0] n_issued;
        logic [SW-1:0] n_stall;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: dispatch sequence numbers give age order.
    int            m_seq [N];
    int            m_cnt;
    logic [N-1:0]  m_ev;
    logic [N-1:0]  m_iss;
    logic          m_gv;
    logic [IW-1:0] m_gidx;
    logic [SW-1:0] m_nissued;
    logic [SW-1:0] m_nstall;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_seq[i] = 0;
        m_cnt     = 0;
        m_ev      = '0;
        m_iss     = '0;
        m_gv      = 1'b0;
        m_gidx    = '0;
        m_nissued = '0;
        m_nstall  = '0;
    endtask

    task automatic model_edge(input logic dv, input int de, input logic [N-1:0] rq,
                              input logic fl, input logic fr);
        logic         acc;
        logic [N-1:0] cand;
        int           pick;
        exp_t         e;
        acc = m_gv && fr && !fl;
        if (m_gv && !fr && m_nstall != '1) m_nstall = m_nstall + 1;
        if (acc && m_nissued != '1) m_nissued = m_nissued + 1;
        if (fl) begin
            m_gv   = 1'b0;
            m_gidx = '0;
            m_iss  = '0;
            m_ev   = '0;
        end else begin
            cand = rq & m_ev & ~m_iss;
            if (acc) cand[m_gidx] = 1'b0;
            pick = -1;
            for (int i = 0; i < N; i++) begin
                if (cand[i] && (pick < 0 || m_seq[i] < m_seq[pick])) pick = i;
            end
            if (acc) m_iss[m_gidx] = 1'b1;
            if (!m_gv || fr) begin
                m_gv   = (pick >= 0);
                m_gidx = (pick >= 0) ? IW'(pick) : '0;
            end
            if (dv) begin
                m_cnt      = m_cnt + 1;
                m_seq[de]  = m_cnt;
                m_ev[de]   = 1'b1;
                m_iss[de]  = 1'b0;
            end
        end
        e.gv       = m_gv;
        e.gidx     = m_gidx;
        e.grant    = m_gv ? (N'(1) << m_gidx) : '0;
        e.iss      = m_iss;
        e.n_issued = m_nissued;
        e.n_stall  = m_nstall;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq("grant_valid", 32'(bus.grant_valid), 32'(e.gv));
            check_eq("grant",       32'(bus.grant),       32'(e.grant));
            check_eq("grant_idx",   32'(bus.grant_idx),   32'(e.gidx));
            check_eq("issued_mask", 32'(bus.issued_mask), 32'(e.iss));
`ifdef ISSUE_SELECT_STATS_EN
            check_eq("stat_issued", stat_issued, e.n_issued);
            check_eq("stat_stall",  stat_stall,  e.n_stall);
`endif
        end
    endtask

    // One clock cycle: drive at negedge, predict, compare just after posedge.
    task automatic step(input logic dv, input int de, input logic [N-1:0] rq,
                        input logic fl, input logic fr);
        @(negedge clk);
        bus.disp_valid = dv;
        bus.disp_entry = IW'(de);
        bus.reqs       = rq;
        bus.flush      = fl;
        bus.fu_ready   = fr;
        model_edge(dv, de, rq, fl, fr);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic do_flush();
        step(1'b0, 0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.disp_valid = 1'b0;
        bus.disp_entry = '0;
        bus.reqs       = '0;
        bus.flush      = 1'b0;
        bus.fu_ready   = 1'b0;
        model_reset();
        #3;
        check_eq("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        check_eq("rst_grant",       32'(bus.grant),       32'd0);
        check_eq("rst_grant_idx",   32'(bus.grant_idx),   32'd0);
        check_eq("rst_issued_mask", 32'(bus.issued_mask), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // All-zero requests keep the grant idle.
        repeat (3) step(1'b0, 0, 8'h00, 1'b0, 1'b1);
        check_eq("idle_grant_valid", 32'(bus.grant_valid), 32'd0);

        // Age order: dispatch 3, 1, 6 then request all three.
        step(1'b1, 3, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1, 8'h00, 1'b0, 1'b1);
        step(1'b1, 6, 8'h00, 1'b0, 1'b1);
        step(1'b0, 0, 8'h4A, 1'b0, 1'b1);
        check_eq("age_grant0", 32'(bus.grant), 32'h08);
        step(1'b0, 0, 8'h4A, 1'b0, 1'b1);
        check_eq("age_grant1", 32'(bus.grant), 32'h02);
        step(1'b0, 0, 8'h4A, 1'b0, 1'b1);
        check_eq("age_grant2", 32'(bus.grant_idx), 32'd6);
        step(1'b0, 0, 8'h4A, 1'b0, 1'b1);
        check_eq("age_done_valid", 32'(bus.grant_valid), 32'd0);
        check_eq("age_issued", 32'(bus.issued_mask), 32'h4A);

        // Stall hold: grant for entry 0 held while the FU is not ready.
        do_flush();
        step(1'b1, 0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 2, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 0, 8'h05, 1'b0, 1'b0);
            check_eq("stall_hold", 32'(bus.grant), 32'h01);
        end
        step(1'b0, 0, 8'h05, 1'b0, 1'b1);
        check_eq("stall_release", 32'(bus.grant), 32'h04);

        // Flush during stall drops the grant; old entries stay ignored.
        step(1'b0, 0, 8'h05, 1'b0, 1'b0);
        step(1'b0, 0, 8'h05, 1'b1, 1'b0);
        check_eq("flush_valid", 32'(bus.grant_valid), 32'd0);
        check_eq("flush_issued", 32'(bus.issued_mask), 32'd0);
        repeat (3) step(1'b0, 0, 8'h05, 1'b0, 1'b1);
        check_eq("flush_ignore", 32'(bus.grant_valid), 32'd0);

        // No double issue, then re-dispatch reopens the entry.
        step(1'b1, 5, 8'h20, 1'b0, 1'b1);
        step(1'b0, 0, 8'h20, 1'b0, 1'b1);
        check_eq("single_issue", 32'(bus.grant), 32'h20);
        repeat (3) step(1'b0, 0, 8'h20, 1'b0, 1'b1);
        check_eq("no_double_issue", 32'(bus.grant_valid), 32'd0);
        step(1'b1, 5, 8'h20, 1'b0, 1'b1);
        step(1'b0, 0, 8'h20, 1'b0, 1'b1);
        check_eq("reissue_5", 32'(bus.grant), 32'h20);

        // Re-dispatched entry becomes the youngest.
        do_flush();
        step(1'b1, 2, 8'h00, 1'b0, 1'b1);
        step(1'b1, 4, 8'h00, 1'b0, 1'b1);
        step(1'b1, 2, 8'h00, 1'b0, 1'b1);
        step(1'b0, 0, 8'h14, 1'b0, 1'b1);
        check_eq("redisp_first", 32'(bus.grant_idx), 32'd4);
        step(1'b0, 0, 8'h14, 1'b0, 1'b1);
        check_eq("redisp_second", 32'(bus.grant_idx), 32'd2);
        step(1'b0, 0, 8'h00, 1'b0, 1'b1);

        // Random traffic against the model.
        for (int k = 0; k < 60; k++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                 N'($urandom), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
        end

        // Async reset between edges while a grant is valid.
        do_flush();
        step(1'b1, 1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 0, 8'h02, 1'b0, 1'b0);
        check_eq("pre_rst_valid", 32'(bus.grant_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("arst_valid",  32'(bus.grant_valid), 32'd0);
        check_eq("arst_grant",  32'(bus.grant),       32'd0);
        check_eq("arst_issued", 32'(bus.issued_mask), 32'd0);
        sb.delete();
        model_reset();
        bus.reqs = '0;
        @(negedge clk);
        rst = 1'b0;

        // Three accepts and two stall cycles from a clean start.
        step(1'b1, 0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1, 8'h00, 1'b0, 1'b1);
        step(1'b1, 2, 8'h00, 1'b0, 1'b1);
        step(1'b0, 0, 8'h07, 1'b0, 1'b0);
        step(1'b0, 0, 8'h07, 1'b0, 1'b0);
        step(1'b0, 0, 8'h07, 1'b0, 1'b0);
        step(1'b0, 0, 8'h07, 1'b0, 1'b1);
        step(1'b0, 0, 8'h07, 1'b0, 1'b1);
        step(1'b0, 0, 8'h07, 1'b0, 1'b1);
        check_eq("stats_seq_done", 32'(bus.issued_mask), 32'h07);
`ifdef ISSUE_SELECT_STATS_EN
        check_eq("stat_issued_3", stat_issued, 32'd3);
        check_eq("stat_stall_2",  stat_stall,  32'd2);
        do_flush();
        check_eq("stat_keep_flush", stat_issued, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/issue_select.md
Name: issue_select

Overview:
- Select stage directly downstream of the wakeup block.
- Each cycle it takes the ready-request vector from wakeup and picks the oldest requesting RS entry by dispatch order, using an age matrix.
- It presents a registered one-hot grant to the functional unit with a valid/ready handshake; the same grant is fed back to wakeup.
- A local issued mask prevents double issue while wakeup has not yet retired the entry.

Parameters:
- RS_ENTRIES, 8, number of reservation-station entries; must match wakeup.
- IDX_W, $clog2(RS_ENTRIES), width of an entry index.
- STAT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-high reset.
- disp_valid  input  1  an entry is being dispatched this cycle.
- disp_entry  input  IDX_W  index of the dispatched entry (wakeup free_entry_out).
- reqs  input  RS_ENTRIES  per-entry ready requests from wakeup.
- flush  input  1  synchronous pipeline flush.
- fu_ready  input  1  FU accepts the presented grant this cycle.
- grant  output  RS_ENTRIES  registered one-hot grant.
- grant_idx  output  IDX_W  binary index of grant.
- grant_valid  output  1  grant is valid.
- issued_mask  output  RS_ENTRIES  entries accepted by the FU and not yet re-dispatched.

Behaviour:
- Reset (async, rst=1): grant=0, grant_idx=0, grant_valid=0, issued_mask=0, age matrix=0, entry-valid vector=0.
- Age matrix age[i][j]=1 means entry i is older than entry j. Entry-valid vector ev tracks which entries have been dispatched.
- Dispatch of entry e (disp_valid=1), applied at the clock edge:
  - age[e][*]=0, age[*][e]=ev (e becomes the youngest).
  - ev[e]=1, issued_mask[e]=0.
  - Re-dispatching an entry that is already valid is legal: it is treated as the youngest.
- Candidates: cand = reqs & ev & ~issued_mask & ~accept_onehot.
  - accept_onehot = grant when grant_valid && fu_ready, else 0.
  - Requests from invalid entries are ignored.
- Oldest pick: entry i wins if cand[i] and, for every j≠i with cand[j], age[i][j]=1. The result is exactly one-hot, or zero if cand=0.
- Handshake and latency:
  - Selection is registered: reqs sampled at cycle N give grant_valid at N+1.
  - If grant_valid && !fu_ready (stall): grant, grant_idx and grant_valid hold stable and no new selection is loaded.
  - If grant_valid && fu_ready (accept): issued_mask[grant_idx] is set at the edge, and the register loads the next pick (or grant_valid=0 if none). This gives back-to-back issue of one entry per cycle.
  - If !grant_valid: the register loads the current pick.
  - grant_idx always equals the encoded grant.
- A dispatch and a select in the same cycle both use pre-edge age and ev. The newly dispatched entry cannot win that cycle.
- issued_mask[e] and ev[e] remain set until e is re-dispatched (wakeup retirement is observed through reqs dropping).
- Flush (synchronous, highest priority except reset): grant_valid=0, grant=0, grant_idx=0, issued_mask=0, ev=0. A flush during a stall drops the grant with no accept. disp_valid in the same cycle is ignored.
- Reset mid-operation clears everything immediately, regardless of clk.
- Width rules: IDX_W index encode; no arithmetic except the optional counters.
- An all-zero reqs vector in steady state must keep grant_valid=0.

Optional Feature:
- Macro: ISSUE_SELECT_STATS_EN.
- Defined: adds output ports stat_issued [STAT_W] and stat_stall [STAT_W].
  - stat_issued increments on each accept.
  - stat_stall increments each cycle with grant_valid && !fu_ready.
  - Both saturate at all-ones, are cleared by rst, and are not cleared by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Age order: dispatch entries 3, 1, 6 in consecutive cycles; drive reqs=8'b0100_1010 with fu_ready=1 -> grants 8'b0000_1000, 8'b0000_0010, 8'b0100_0000 on successive cycles (grant_idx 3, 1, 6), then grant_valid=0; issued_mask=8'b0100_1010.
- Stall hold: dispatch 0 and 2, reqs=8'b0000_0101, fu_ready=0 for 4 cycles -> grant_valid=1, grant=8'b0000_0001 held all 4 cycles; raise fu_ready -> next cycle grant=8'b0000_0100.
- No double issue: dispatch 5, reqs[5] held high, fu_ready=1 -> exactly one grant for 5, then grant_valid=0 while reqs[5] stays 1. Re-dispatch 5 -> a new grant for 5 two cycles later.
- Re-dispatch youngest: dispatch 2 then 4, re-dispatch 2, reqs=8'b0001_0100 -> first grant is entry 4, then entry 2.
- Flush during stall: grant_valid=1, fu_ready=0, pulse flush -> next cycle grant_valid=0, issued_mask=0, ev=0; reqs from previously dispatched entries are ignored until re-dispatch.
- Async reset: assert rst between clock edges while grant_valid=1 -> grant, grant_valid and issued_mask are 0 before the next posedge. With ISSUE_SELECT_STATS_EN, after 3 accepts and 2 stall cycles -> stat_issued=3, stat_stall=2.
